tmr_voter_seq: RTL and testbench
================================

Name: tmr_voter_seq

Overview:
- Registered, parametrised triple-modular-redundancy word voter with a valid qualifier.
- Per-channel fault monitoring: consecutive disagreements are counted, and a channel is declared faulty at a threshold.
- A faulty channel is excluded from voting; the block degrades to two-channel compare.
- Sits between three replicated datapaths and downstream consumers; fault flags go to the status/CSR logic.

Parameters:
- WIDTH, 8, bit width of each channel word and of out.
- FAULT_THRESH, 4, consecutive mismatching valid beats needed to declare a channel faulty; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of each per-channel mismatch counter.
- ERRCNT_W, 16, width of err_count (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  the in1/in2/in3 beat is valid this cycle.
- in1  in  WIDTH  channel 0 word.
- in2  in  WIDTH  channel 1 word.
- in3  in  WIDTH  channel 2 word.
- clear_fault  in  1  pulse; clears all faulty flags and counters.
- out_valid  out  1  out/error are valid (registered in_valid).
- out  out  WIDTH  voted word.
- error  out  1  no majority on this beat.
- mismatch  out  3  per-channel disagreement with the voted word on this beat.
- faulty  out  3  sticky per-channel fault flags.
- err_count  out  ERRCNT_W  saturating count of error beats (only with TMR_VOTER_STATS_EN).

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, out=0, error=0, mismatch=0, faulty=0, all counters=0, err_count=0.
- Latency: all outputs are registered, 1 cycle after the in_valid beat.
- Idle cycles: when in_valid=0, out_valid=0, out holds its value, error=0, mismatch=0, and counters and flags hold.
- Healthy set H = channels with faulty=0. At most one channel can be faulty at a time, because counting requires a majority.
- Voting, |H|=3, word-level:
  - in1==in2 gives in1.
  - Otherwise in2==in3 gives in2.
  - Otherwise in1==in3 gives in3.
  - Otherwise error=1, out=0, mismatch=0.
- Voting, |H|=2: if the two healthy words are equal, out=that word and error=0. Otherwise error=1 and out=0. The faulty channel's word is ignored.
- mismatch[i]: set to 1 on a non-error beat when channel i is healthy and its word differs from the voted word. Faulty channels report mismatch=0.
- Per-channel FSM, one per channel:
  - HEALTHY (cnt=0) goes to SUSPECT on a mismatch beat, with cnt=1.
  - SUSPECT:
    - A mismatch beat increments cnt.
    - An agreeing beat returns to HEALTHY with cnt=0.
    - If cnt+1 reaches FAULT_THRESH, go to FAULTY (faulty[i]=1).
  - FAULTY holds until clear_fault or rst.
  - Error beats and idle cycles leave all FSMs unchanged.
  - FAULT_THRESH=1 goes from HEALTHY directly to FAULTY on the first mismatch.
- Counters never wrap; the threshold is reached before saturation.
- clear_fault together with a valid beat: the vote uses the pre-clear faulty set. FSM updates are overridden, so all channels become HEALTHY with cnt=0, and mismatch outputs still reflect that beat.
- rst mid-stream: all state returns to reset values on the next edge, and the in-flight beat is dropped (out_valid=0).

Optional Feature:
- Macro: TMR_VOTER_STATS_EN.
- Defined: err_count port exists. It increments on each output beat with error=1, saturates at all-ones, and clears on rst or clear_fault (clear wins over a same-cycle increment).
- Undefined: the port and counter are absent, and no other behaviour changes.

Decomposition:
- Package tmr_pkg:
  - Channel index constants CH0/CH1/CH2 = 0/1/2 and NUM_CH=3.
  - Channel state enum {HEALTHY, SUSPECT, FAULTY}.
- Sub-module tmr_channel_monitor, instantiated 3x. It holds the FSM and CNT_W counter.
  - Inputs: clk, rst, clear, beat_valid, beat_error, disagree.
  - Output: faulty.
- The top level holds the combinational vote, mismatch generation, and output registers.

Test Plan (WIDTH=8, FAULT_THRESH=4):
- Reset, then in1=in2=in3=8'hA5 with in_valid=1 → next cycle out=A5, out_valid=1, error=0, mismatch=000.
- in1=A5, in2=3C, in3=A5 → out=A5, mismatch=010; three more such beats → faulty=010 after the 4th; beats at 1–3 leave faulty=000.
- Channel 1 faulty, in1=11, in2=11, in3=22 → error=1, out=00, mismatch=000 (in2 ignored).
- Three mismatch beats on ch2, then one agreeing beat, then three more mismatches → faulty stays 000 (counter reset by agreement).
- In1=01, in2=02, in3=03 → error=1, out=00; counters unchanged; with TMR_VOTER_STATS_EN, err_count increments 0→1.
- Faulty=001 with clear_fault and a valid beat on the same cycle → next cycle faulty=000; rst asserted while in_valid=1 → out_valid=0 and all outputs at reset values.

Source files
------------

// File: rtl/tmr_voter_seq_pkg.sv
// Shared channel indices and per-channel health state for the TMR voter.
// Optional statistics are enabled with the TMR_VOTER_STATS_EN macro.
package tmr_pkg;

  localparam int CH0    = 0;
  localparam int CH1    = 1;
  localparam int CH2    = 2;
  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAULTY  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/tmr_voter_seq_if.sv
// Bundles the replicated-channel beat, the voted result and the fault status.
// err_count is present only when TMR_VOTER_STATS_EN is defined.
interface tmr_voter_seq_if #(
  parameter int WIDTH    = 8,
  parameter int ERRCNT_W = 16
);

  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             clear_fault;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             error;
  logic [2:0]       mismatch;
  logic [2:0]       faulty;
`ifdef TMR_VOTER_STATS_EN
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    output in_valid, in1, in2, in3, clear_fault,
    input  out_valid, out, error, mismatch, faulty, err_count
  );

  modport slave (
    input  in_valid, in1, in2, in3, clear_fault,
    output out_valid, out, error, mismatch, faulty, err_count
  );
`else
  modport master (
    output in_valid, in1, in2, in3, clear_fault,
    input  out_valid, out, error, mismatch, faulty
  );

  modport slave (
    input  in_valid, in1, in2, in3, clear_fault,
    output out_valid, out, error, mismatch, faulty
  );
`endif

endinterface

// File: rtl/tmr_voter_seq_channel_monitor.sv
// Per-channel health FSM: counts consecutive disagreeing valid beats and
// latches a sticky fault once the count reaches FAULT_THRESH.
module tmr_channel_monitor
  import tmr_pkg::*;
#(
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic beat_valid,
  input  logic beat_error,
  input  logic disagree,
  output logic faulty
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HEALTHY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only beats that produced a vote count; error beats and idle cycles hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = HEALTHY;
      cnt_d   = '0;
    end else if (beat_valid && !beat_error) begin
      unique case (state_q)
        HEALTHY: begin
          if (disagree) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc >= THRESH) ? FAULTY : SUSPECT;
          end
        end
        SUSPECT: begin
          if (disagree) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc >= THRESH) ? FAULTY : SUSPECT;
          end else begin
            cnt_d   = '0;
            state_d = HEALTHY;
          end
        end
        FAULTY:  state_d = FAULTY;
        default: begin
          state_d = HEALTHY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    faulty = (state_q == FAULTY);
  end

endmodule

// File: rtl/tmr_voter_seq.sv
// Registered TMR word voter with per-channel fault exclusion.
// Define TMR_VOTER_STATS_EN to add the saturating err_count output.
module tmr_voter_seq
  import tmr_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 4,
  parameter int ERRCNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  tmr_voter_seq_if.slave bus
);

  logic [WIDTH-1:0]  words [NUM_CH];
  logic [NUM_CH-1:0] faulty_w;
  logic [WIDTH-1:0]  vote_word;
  logic              vote_err;
  logic [NUM_CH-1:0] vote_mm;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              error_q, error_d;
  logic [NUM_CH-1:0] mismatch_q, mismatch_d;

  assign words[CH0] = bus.in1;
  assign words[CH1] = bus.in2;
  assign words[CH2] = bus.in3;

  // The vote always uses the fault set as it stood before this edge.
  always_comb begin
    vote_word = '0;
    vote_err  = 1'b1;
    unique case (faulty_w)
      3'b000: begin
        if (words[CH0] == words[CH1]) begin
          vote_word = words[CH0];
          vote_err  = 1'b0;
        end else if (words[CH1] == words[CH2]) begin
          vote_word = words[CH1];
          vote_err  = 1'b0;
        end else if (words[CH0] == words[CH2]) begin
          vote_word = words[CH2];
          vote_err  = 1'b0;
        end
      end
      3'b001: if (words[CH1] == words[CH2]) begin vote_word = words[CH1]; vote_err = 1'b0; end
      3'b010: if (words[CH0] == words[CH2]) begin vote_word = words[CH0]; vote_err = 1'b0; end
      3'b100: if (words[CH0] == words[CH1]) begin vote_word = words[CH0]; vote_err = 1'b0; end
      default: begin
        vote_word = '0;
        vote_err  = 1'b1;
      end
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      vote_mm[i] = !vote_err && !faulty_w[i] && (words[i] != vote_word);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_mon
      tmr_channel_monitor #(
        .FAULT_THRESH (FAULT_THRESH),
        .CNT_W        (CNT_W)
      ) u_mon (
        .clk        (clk),
        .rst        (rst),
        .clear      (bus.clear_fault),
        .beat_valid (bus.in_valid),
        .beat_error (vote_err),
        .disagree   (vote_mm[gi]),
        .faulty     (faulty_w[gi])
      );
    end
  endgenerate

  always_comb begin
    out_valid_d = bus.in_valid;
    out_d       = bus.in_valid ? vote_word : out_q;
    error_d     = bus.in_valid && vote_err;
    mismatch_d  = bus.in_valid ? vote_mm : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      error_q     <= 1'b0;
      mismatch_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      error_q     <= error_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.error     = error_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.faulty    = faulty_w;

`ifdef TMR_VOTER_STATS_EN
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  // A clear on the same cycle as an error beat leaves the count at zero.
  always_comb begin
    err_count_d = err_count_q;
    if (bus.clear_fault) begin
      err_count_d = '0;
    end else if (error_d && !(&err_count_q)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_tmr_voter_seq.sv
// Directed and randomized checks of tmr_voter_seq against a majority-vote model.
// Define TMR_VOTER_STATS_EN to also check err_count.
module tb_tmr_voter_seq;

  localparam int WIDTH        = 8;
  localparam int FAULT_THRESH = 4;
  localparam int CNT_W        = 4;
  localparam int ERRCNT_W     = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tmr_voter_seq_if #(.WIDTH(WIDTH), .ERRCNT_W(ERRCNT_W)) bus ();

  tmr_voter_seq #(
    .WIDTH        (WIDTH),
    .FAULT_THRESH (FAULT_THRESH),
    .CNT_W        (CNT_W),
    .ERRCNT_W     (ERRCNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: per-channel consecutive-miss counts and fault flags.
  int         m_cnt [3];
  logic [2:0] m_faulty;
  logic       exp_ov;
  logic [7:0] exp_out;
  logic       exp_err;
  logic [2:0] exp_mm;
  int         exp_errcnt;

  logic [15:0] obs;
  logic [15:0] exp_vec;
  assign obs     = {bus.out_valid, bus.out, bus.error, bus.mismatch, bus.faulty};
  assign exp_vec = {exp_ov, exp_out, exp_err, exp_mm, m_faulty};

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_faulty = 3'b000;
  endtask

  task automatic beat(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic clr);
    logic [7:0] w [3];
    logic       found;
    logic [7:0] maj;
    w[0] = a; w[1] = b; w[2] = c;
    found = 1'b0;
    maj   = 8'h00;
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 3; j++)
        if (!found && !m_faulty[i] && !m_faulty[j] && w[i] == w[j]) begin
          found = 1'b1;
          maj   = w[i];
        end
    exp_ov = v;
    if (v) begin
      exp_err = !found;
      exp_out = found ? maj : 8'h00;
      for (int i = 0; i < 3; i++) exp_mm[i] = found && !m_faulty[i] && (w[i] != maj);
    end else begin
      exp_err = 1'b0;
      exp_mm  = 3'b000;
    end
    if (clr) begin
      model_clear();
    end else if (v && found) begin
      for (int i = 0; i < 3; i++)
        if (!m_faulty[i]) begin
          if (exp_mm[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] >= FAULT_THRESH) m_faulty[i] = 1'b1;
          end else begin
            m_cnt[i] = 0;
          end
        end
    end
    if (clr) exp_errcnt = 0;
    else if (v && !found && exp_errcnt < (1 << ERRCNT_W) - 1) exp_errcnt++;
    bus.in_valid    = v;
    bus.in1         = a;
    bus.in2         = b;
    bus.in3         = c;
    bus.clear_fault = clr;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.clear_fault = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    exp_ov = 0; exp_out = 0; exp_err = 0; exp_mm = 0; exp_errcnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", obs, 16'h0000);
    end
    beat(1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    n_checks++;
    if (obs !== {1'b1, 8'hA5, 1'b0, 3'b000, 3'b000}) begin
      n_fail++;
      $display("FAIL all_agree: got %h required %h", obs, {1'b1, 8'hA5, 1'b0, 3'b000, 3'b000});
    end
    beat(1'b0, 8'h00, 8'h11, 8'h22, 1'b0);
    n_checks++;
    if (obs !== {1'b0, 8'hA5, 1'b0, 3'b000, 3'b000}) begin
      n_fail++;
      $display("FAIL idle_hold: got %h required %h", obs, {1'b0, 8'hA5, 1'b0, 3'b000, 3'b000});
    end
  endtask

  task automatic test_fault_detect();
    for (int k = 1; k <= 4; k++) begin
      beat(1'b1, 8'hA5, 8'h3C, 8'hA5, 1'b0);
      n_checks++;
      if (obs !== {1'b1, 8'hA5, 1'b0, 3'b010, (k == 4) ? 3'b010 : 3'b000}) begin
        n_fail++;
        $display("FAIL fault_detect beat %0d: got %h required %h", k, obs,
                 {1'b1, 8'hA5, 1'b0, 3'b010, (k == 4) ? 3'b010 : 3'b000});
      end
    end
  endtask

  task automatic test_degraded();
    beat(1'b1, 8'h11, 8'h11, 8'h22, 1'b0);
    n_checks++;
    if (obs !== {1'b1, 8'h00, 1'b1, 3'b000, 3'b010}) begin
      n_fail++;
      $display("FAIL degraded_error: got %h required %h", obs, {1'b1, 8'h00, 1'b1, 3'b000, 3'b010});
    end
    beat(1'b1, 8'h66, 8'h99, 8'h66, 1'b0);
    n_checks++;
    if (obs !== {1'b1, 8'h66, 1'b0, 3'b000, 3'b010}) begin
      n_fail++;
      $display("FAIL degraded_agree: got %h required %h", obs, {1'b1, 8'h66, 1'b0, 3'b000, 3'b010});
    end
    beat(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if (bus.faulty !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_clear: got %b required %b", bus.faulty, 3'b000);
    end
  endtask

  task automatic test_agreement_resets();
    for (int k = 0; k < 7; k++) begin
      if (k == 3) beat(1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0);
      else        beat(1'b1, 8'h5A, 8'h5A, 8'hC3, 1'b0);
    end
    n_checks++;
    if (obs !== {1'b1, 8'h5A, 1'b0, 3'b100, 3'b000}) begin
      n_fail++;
      $display("FAIL agree_resets_cnt: got %h required %h", obs, {1'b1, 8'h5A, 1'b0, 3'b100, 3'b000});
    end
    // The counter is now at 3, so one more miss must trip the fault.
    beat(1'b1, 8'h5A, 8'h5A, 8'hC3, 1'b0);
    n_checks++;
    if (bus.faulty !== 3'b100) begin
      n_fail++;
      $display("FAIL thresh_after_agree: got %b required %b", bus.faulty, 3'b100);
    end
    beat(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_no_majority();
    beat(1'b1, 8'h01, 8'h01, 8'h7E, 1'b0);
    beat(1'b1, 8'h01, 8'h02, 8'h03, 1'b0);
    n_checks++;
    if (obs !== {1'b1, 8'h00, 1'b1, 3'b000, 3'b000}) begin
      n_fail++;
      $display("FAIL no_majority: got %h required %h", obs, {1'b1, 8'h00, 1'b1, 3'b000, 3'b000});
    end
`ifdef TMR_VOTER_STATS_EN
    n_checks++;
    if (bus.err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL err_count_inc: got %0d required %0d", bus.err_count, 1);
    end
`endif
    // Error beats must not disturb counters: two more misses on ch2 stay healthy.
    beat(1'b1, 8'h01, 8'h01, 8'h7E, 1'b0);
    beat(1'b1, 8'h01, 8'h01, 8'h7E, 1'b0);
    n_checks++;
    if (bus.faulty !== 3'b000) begin
      n_fail++;
      $display("FAIL error_holds_cnt: got %b required %b", bus.faulty, 3'b000);
    end
    beat(1'b1, 8'h01, 8'h01, 8'h7E, 1'b0);
    n_checks++;
    if (bus.faulty !== 3'b100) begin
      n_fail++;
      $display("FAIL error_holds_trip: got %b required %b", bus.faulty, 3'b100);
    end
    beat(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_clear_and_rst();
    for (int k = 0; k < 4; k++) beat(1'b1, 8'h77, 8'h55, 8'h55, 1'b0);
    n_checks++;
    if (bus.faulty !== 3'b001) begin
      n_fail++;
      $display("FAIL ch0_faulty: got %b required %b", bus.faulty, 3'b001);
    end
    beat(1'b1, 8'h77, 8'h55, 8'h55, 1'b1);
    n_checks++;
    if (obs !== {1'b1, 8'h55, 1'b0, 3'b000, 3'b000}) begin
      n_fail++;
      $display("FAIL clear_with_beat: got %h required %h", obs, {1'b1, 8'h55, 1'b0, 3'b000, 3'b000});
    end
    beat(1'b1, 8'h77, 8'h55, 8'h55, 1'b0);
    n_checks++;
    if (obs !== {1'b1, 8'h55, 1'b0, 3'b001, 3'b000}) begin
      n_fail++;
      $display("FAIL after_clear_vote: got %h required %h", obs, {1'b1, 8'h55, 1'b0, 3'b001, 3'b000});
    end
    bus.in_valid = 1'b1;
    bus.in1 = 8'h12; bus.in2 = 8'h12; bus.in3 = 8'h34;
    do_reset();
    bus.in_valid = 1'b0;
    n_checks++;
    if (obs !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_midstream: got %h required %h", obs, 16'h0000);
    end
  endtask

  task automatic test_random();
    int bad_ch;
    logic [7:0] base;
    logic [7:0] w [3];
    bad_ch = 0;
    for (int k = 0; k < 600; k++) begin
      if (k % 60 == 0) bad_ch = $urandom_range(0, 2);
      base = 8'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        w[i] = base;
        if ((i == bad_ch && $urandom_range(0, 9) < 7) || $urandom_range(0, 9) == 0)
          w[i] = 8'($urandom_range(0, 7));
      end
      beat($urandom_range(0, 9) < 8, w[0], w[1], w[2], $urandom_range(0, 39) == 0);
      n_checks++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL random beat %0d: got %h required %h", k, obs, exp_vec);
      end
`ifdef TMR_VOTER_STATS_EN
      n_checks++;
      if (bus.err_count !== ERRCNT_W'(exp_errcnt)) begin
        n_fail++;
        $display("FAIL random err_count %0d: got %0d required %0d", k, bus.err_count, exp_errcnt);
      end
`endif
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    bus.clear_fault = 1'b0;
    model_clear();
    exp_ov = 0; exp_out = 0; exp_err = 0; exp_mm = 0; exp_errcnt = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_fault_detect();
    test_degraded();
    test_agreement_resets();
    test_no_majority();
    test_clear_and_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
